// File: rtl/noc_port_requester.sv
// noc_port_requester: per-port flit FIFO + req/grant FSM; define NOC_PORT_PKT_CHECK_EN for err/err_cnt packet checking
module noc_port_requester #(
  parameter int DATA_W = 32,
  parameter int LEN_W = 12,
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_flit_id,
  input  logic [DATA_W-1:0] in_data,
  input  logic              grant,
  output logic              req,
  output logic [2:0]        flit_id,
  output logic [LEN_W-1:0]  length,
  output logic              out_valid,
  output logic [2:0]        out_flit_id,
  output logic [DATA_W-1:0] out_data
`ifdef NOC_PORT_PKT_CHECK_EN
  ,
  output logic              err,
  output logic [7:0]        err_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [2:0] HDR = 3'b001;
  localparam logic [2:0] TAIL = 3'b100;
  typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;
  state_t state, state_nxt;
  logic [DATA_W+2:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic push, pop, fwd, empty, full;
  logic [2:0] head_id;
  logic [DATA_W-1:0] head_data;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign in_ready = !full;
  assign push = in_valid && !full;
  assign {head_id, head_data} = mem[rd_ptr];
  assign flit_id = empty ? 3'b000 : head_id;
  assign length = head_data[LEN_W-1:0];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_flit_id, in_data};
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (!empty && head_id == HDR ? REQ : IDLE)
              : state == REQ  ? (pop ? SEND : REQ)
              : (pop && head_id == TAIL ? IDLE : SEND);
  always_comb begin
    req = state != IDLE;
    fwd = state != IDLE && grant && !empty;
    pop = fwd || (state == IDLE && !empty && head_id != HDR);
  end
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_flit_id <= '0;
      out_data <= '0;
    end else begin
      out_valid <= fwd;
      if (fwd) begin
        out_flit_id <= head_id;
        out_data <= head_data;
      end
    end
`ifdef NOC_PORT_PKT_CHECK_EN
  logic [LEN_W:0] pkt_cnt;
  logic [LEN_W-1:0] pkt_len;
  logic err_ev;
  assign err_ev = (pop && !fwd)
               || (fwd && state == SEND && head_id == HDR)
               || (fwd && head_id == TAIL && pkt_cnt + 1'b1 != {1'b0, pkt_len});
  always_ff @(posedge clk)
    if (rst) begin
      pkt_cnt <= '0;
      pkt_len <= '0;
      err <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (fwd) pkt_cnt <= head_id == HDR ? (LEN_W+1)'(1) : pkt_cnt + 1'b1;
      if (fwd && head_id == HDR) pkt_len <= length;
      if (err_ev) err <= 1'b1;
      if (err_ev && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_noc_port_requester.sv
// tb_noc_port_requester: directed self-checking bench for noc_port_requester
module tb_noc_port_requester;
  localparam logic [2:0] HDR = 3'b001;
  localparam logic [2:0] BODY = 3'b010;
  localparam logic [2:0] TAIL = 3'b100;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, grant, req, out_valid;
  logic [2:0] in_flit_id, flit_id, out_flit_id;
  logic [31:0] in_data, out_data;
  logic [11:0] length;
`ifdef NOC_PORT_PKT_CHECK_EN
  logic err;
  logic [7:0] err_cnt;
`endif
  int n_chk = 0;
  int n_fail = 0;
  int n;
  noc_port_requester dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_flit_id(in_flit_id), .in_data(in_data), .grant(grant), .req(req),
    .flit_id(flit_id), .length(length), .out_valid(out_valid),
    .out_flit_id(out_flit_id), .out_data(out_data)
`ifdef NOC_PORT_PKT_CHECK_EN
    , .err(err), .err_cnt(err_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] id, input logic [31:0] d);
    in_valid = 1'b1;
    in_flit_id = id;
    in_data = d;
  endtask
  task automatic idle;
    in_valid = 1'b0;
    in_flit_id = '0;
    in_data = '0;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    grant = 1'b0;
    idle();
    step();
    step();
    rst = 1'b0;
  endtask
  initial begin
    do_reset();
    check("rst_req", req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_id", out_flit_id, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_flit_id", flit_id, 0);
    grant = 1'b1;
    drive(HDR, 32'hA000_0003);
    step();
    check("t1_req_lat1", req, 0);
    check("t1_head_id", flit_id, HDR);
    check("t1_length", length, 3);
    drive(BODY, 32'h0000_00B1);
    step();
    check("t1_req_lat2", req, 1);
    check("t1_no_out", out_valid, 0);
    drive(TAIL, 32'h0000_00C2);
    step();
    check("t1_hv", out_valid, 1);
    check("t1_hid", out_flit_id, HDR);
    check("t1_hdata", out_data, 32'hA000_0003);
    idle();
    step();
    check("t1_bv", out_valid, 1);
    check("t1_bid", out_flit_id, BODY);
    check("t1_bdata", out_data, 32'hB1);
    check("t1_req_at_tail", req, 1);
    step();
    check("t1_tv", out_valid, 1);
    check("t1_tid", out_flit_id, TAIL);
    check("t1_tdata", out_data, 32'hC2);
    check("t1_req_drop", req, 0);
    step();
    check("t1_ov_end", out_valid, 0);
`ifdef NOC_PORT_PKT_CHECK_EN
    check("t1_err", err, 0);
`endif
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(i == 0 ? HDR : i == 7 ? TAIL : BODY, i);
      step();
      check("t2_in_ready", in_ready, i < 7);
    end
    drive(HDR, 32'h99);
    step();
    check("t2_full_ready", in_ready, 0);
    check("t2_full_req", req, 1);
    check("t2_full_ov", out_valid, 0);
    check("t2_full_head", flit_id, HDR);
    idle();
    grant = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) begin
        check("t2_drain_data", out_data, n);
        check("t2_drain_id", out_flit_id, n == 0 ? HDR : n == 7 ? TAIL : BODY);
        n++;
      end
    end
    check("t2_drain_cnt", n, 8);
    check("t2_drain_req", req, 0);
    check("t2_drain_empty", flit_id, 0);
    do_reset();
    drive(HDR, 32'h5);
    step();
    drive(BODY, 32'h11);
    step();
    drive(BODY, 32'h22);
    step();
    drive(BODY, 32'h33);
    step();
    drive(TAIL, 32'h44);
    step();
    idle();
    step();
    check("t3_req_wait", req, 1);
    check("t3_ov_wait", out_valid, 0);
    grant = 1'b1;
    step();
    check("t3_h", out_data, 32'h5);
    step();
    check("t3_b1", out_data, 32'h11);
    grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_gap_ov", out_valid, 0);
      check("t3_gap_req", req, 1);
    end
    grant = 1'b1;
    step();
    check("t3_b2_v", out_valid, 1);
    check("t3_b2", out_data, 32'h22);
    step();
    check("t3_b3", out_data, 32'h33);
    step();
    check("t3_t", out_data, 32'h44);
    check("t3_tid", out_flit_id, TAIL);
    check("t3_req_end", req, 0);
`ifdef NOC_PORT_PKT_CHECK_EN
    check("t3_err", err, 0);
`endif
    do_reset();
    drive(BODY, 32'h55);
    step();
    idle();
    check("t4_head", flit_id, BODY);
    check("t4_req0", req, 0);
    step();
    check("t4_ov", out_valid, 0);
    check("t4_req1", req, 0);
    check("t4_discard", flit_id, 0);
    step();
    check("t4_ov2", out_valid, 0);
    check("t4_req2", req, 0);
`ifdef NOC_PORT_PKT_CHECK_EN
    check("t4_err", err, 1);
    check("t4_err_cnt", err_cnt, 1);
`endif
    do_reset();
    grant = 1'b1;
    drive(HDR, 32'h3);
    step();
    drive(BODY, 32'h66);
    step();
    idle();
    check("t5_req", req, 1);
    step();
    check("t5_h", out_flit_id, HDR);
    step();
    check("t5_b", out_data, 32'h66);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_gap_ov", out_valid, 0);
      check("t5_gap_req", req, 1);
    end
    drive(TAIL, 32'h77);
    step();
    idle();
    check("t5_push_ov", out_valid, 0);
    check("t5_push_req", req, 1);
    step();
    check("t5_tv", out_valid, 1);
    check("t5_t", out_data, 32'h77);
    check("t5_req_end", req, 0);
`ifdef NOC_PORT_PKT_CHECK_EN
    check("t5_err", err, 0);
`endif
    do_reset();
    drive(HDR, 32'h2);
    step();
    drive(BODY, 32'h88);
    step();
    idle();
    check("t6_pre_req", req, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_req", req, 0);
    check("t6_ov", out_valid, 0);
    check("t6_ready", in_ready, 1);
    check("t6_flit_id", flit_id, 0);
    step();
    check("t6_stay_idle", req, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
